// File: rtl/mini_aes_engine_if.sv
// rtl/mini_aes_engine_if.sv - host-side command/result bundle for the Mini-AES engine
interface mini_aes_engine_if;
  logic        bgn;
  logic [1:0]  mode;
  logic [15:0] key_in;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [15:0] key_out;
  logic        busy;
  logic        done;
  logic [2:0]  round;

  modport master (
    output bgn, mode, key_in, data_in,
    input  data_out, key_out, busy, done, round
  );

  modport slave (
    input  bgn, mode, key_in, data_in,
    output data_out, key_out, busy, done, round
  );
endinterface

// File: rtl/mini_aes_engine.sv
// rtl/mini_aes_engine.sv - 16-bit Mini-AES encrypt/decrypt coprocessor, one round per clock
// Optional CRYPTO_TRACE_EN: prints each completed result (simulation only, no logic change).
module mini_aes_engine #(
  parameter int ROUNDS = 2
) (
  input  logic              clk,
  input  logic              rst,
  mini_aes_engine_if.slave  host_io
);
  typedef enum logic [2:0] {IDLE, ENC_RND, EXPAND, DEC_RND, DONE} state_t;

  localparam logic [2:0] LAST_RND = 3'(ROUNDS);
  localparam logic [1:0] MODE_ENC = 2'b01;
  localparam logic [1:0] MODE_DEC = 2'b10;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hE;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hD;  4'h3: sbox = 4'h1;
      4'h4: sbox = 4'h2;  4'h5: sbox = 4'hF;  4'h6: sbox = 4'hB;  4'h7: sbox = 4'h8;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hA;  4'hA: sbox = 4'h6;  4'hB: sbox = 4'hC;
      4'hC: sbox = 4'h5;  4'hD: sbox = 4'h9;  4'hE: sbox = 4'h0;  default: sbox = 4'h7;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'hE;  4'h1: inv_sbox = 4'h3;  4'h2: inv_sbox = 4'h4;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'h1;  4'h5: inv_sbox = 4'hC;  4'h6: inv_sbox = 4'hA;  4'h7: inv_sbox = 4'hF;
      4'h8: inv_sbox = 4'h7;  4'h9: inv_sbox = 4'hD;  4'hA: inv_sbox = 4'h9;  4'hB: inv_sbox = 4'h6;
      4'hC: inv_sbox = 4'hB;  4'hD: inv_sbox = 4'h2;  4'hE: inv_sbox = 4'h0;  default: inv_sbox = 4'h5;
    endcase
  endfunction

  function automatic logic [3:0] rcon(input logic [2:0] r);
    case (r)
      3'd1: rcon = 4'h1;  3'd2: rcon = 4'h2;  3'd3: rcon = 4'h4;  3'd4: rcon = 4'h8;
      3'd5: rcon = 4'h3;  3'd6: rcon = 4'h6;  3'd7: rcon = 4'hC;  default: rcon = 4'h0;
    endcase
  endfunction

  // Multiply by x in GF(2^4) modulo x^4+x+1.
  function automatic logic [3:0] gmul2(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gmul3(input logic [3:0] x);
    return gmul2(x) ^ x;
  endfunction

  function automatic logic [15:0] sub_word(input logic [15:0] d);
    return {sbox(d[15:12]), sbox(d[11:8]), sbox(d[7:4]), sbox(d[3:0])};
  endfunction

  function automatic logic [15:0] inv_sub_word(input logic [15:0] d);
    return {inv_sbox(d[15:12]), inv_sbox(d[11:8]), inv_sbox(d[7:4]), inv_sbox(d[3:0])};
  endfunction

  function automatic logic [15:0] shift_row(input logic [15:0] d);
    return {d[15:12], d[3:0], d[7:4], d[11:8]};
  endfunction

  function automatic logic [15:0] mix_col(input logic [15:0] d);
    return {gmul3(d[15:12]) ^ gmul2(d[11:8]), gmul2(d[15:12]) ^ gmul3(d[11:8]),
            gmul3(d[7:4])   ^ gmul2(d[3:0]),  gmul2(d[7:4])   ^ gmul3(d[3:0])};
  endfunction

  function automatic logic [15:0] key_fwd(input logic [15:0] k, input logic [2:0] r);
    logic [3:0] w4, w5, w6, w7;
    w4 = k[15:12] ^ sbox(k[3:0]) ^ rcon(r);
    w5 = k[11:8] ^ w4;
    w6 = k[7:4] ^ w5;
    w7 = k[3:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  // Recovers K_{r-1} from K_r; w3 must be rebuilt first since w0 depends on Sub(w3).
  function automatic logic [15:0] key_bwd(input logic [15:0] k, input logic [2:0] r);
    logic [3:0] w0, w1, w2, w3;
    w3 = k[3:0] ^ k[7:4];
    w2 = k[7:4] ^ k[11:8];
    w1 = k[11:8] ^ k[15:12];
    w0 = k[15:12] ^ sbox(w3) ^ rcon(r);
    return {w0, w1, w2, w3};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] s_q, s_d, k_q, k_d;
  logic [15:0] data_out_q, data_out_d, key_out_q, key_out_d;
  logic [2:0]  round_q, round_d, rnd_up;
  logic        done_q, done_d;
  logic [15:0] k_fwd, k_bwd, enc_s, dec_s;

  always_comb begin
    rnd_up = round_q + 3'd1;
    k_fwd  = key_fwd(k_q, rnd_up);
    k_bwd  = key_bwd(k_q, round_q);
    enc_s  = shift_row(sub_word(s_q));
    if (rnd_up != LAST_RND) enc_s = mix_col(enc_s);
    enc_s  = enc_s ^ k_fwd;
    dec_s  = (round_q == LAST_RND) ? s_q : mix_col(s_q);
    dec_s  = inv_sub_word(shift_row(dec_s)) ^ k_bwd;
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    k_d        = k_q;
    round_d    = round_q;
    data_out_d = data_out_q;
    key_out_d  = key_out_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_io.bgn && (host_io.mode == MODE_ENC || host_io.mode == MODE_DEC)) begin
          k_d     = host_io.key_in;
          round_d = 3'd0;
          if (host_io.mode == MODE_ENC) begin
            s_d     = host_io.data_in ^ host_io.key_in;
            state_d = ENC_RND;
          end else begin
            s_d     = host_io.data_in;
            state_d = EXPAND;
          end
        end
      end
      ENC_RND: begin
        round_d = rnd_up;
        k_d     = k_fwd;
        s_d     = enc_s;
        if (rnd_up == LAST_RND) state_d = DONE;
      end
      EXPAND: begin
        round_d = rnd_up;
        k_d     = k_fwd;
        if (rnd_up == LAST_RND) begin
          s_d     = s_q ^ k_fwd;
          state_d = DEC_RND;
        end
      end
      DEC_RND: begin
        round_d = round_q - 3'd1;
        k_d     = k_bwd;
        s_d     = dec_s;
        if (round_q == 3'd1) state_d = DONE;
      end
      DONE: begin
        data_out_d = s_q;
        key_out_d  = k_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      k_q        <= '0;
      round_q    <= '0;
      data_out_q <= '0;
      key_out_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      k_q        <= k_d;
      round_q    <= round_d;
      data_out_q <= data_out_d;
      key_out_q  <= key_out_d;
      done_q     <= done_d;
    end
  end

  assign host_io.data_out = data_out_q;
  assign host_io.key_out  = key_out_q;
  assign host_io.done     = done_q;
  assign host_io.busy     = (state_q != IDLE);
  assign host_io.round    = round_q;

`ifdef CRYPTO_TRACE_EN
  logic [1:0] trace_mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trace_mode_q <= '0;
    else if (state_q == IDLE && host_io.bgn) trace_mode_q <= host_io.mode;
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE)
      $display("%0t mini_aes mode=%b data_out=%h key_out=%h", $time, trace_mode_q, s_q, k_q);
  end
`else
  // Untraced build: results are visible only on the output ports.
`endif
endmodule

// File: tb/tb_mini_aes_engine.sv
// tb/tb_mini_aes_engine.sv - randomized self-checking bench for mini_aes_engine
module tb_mini_aes_engine;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  mini_aes_engine_if bus ();

  mini_aes_engine #(.ROUNDS(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .host_io (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] sbox_tab [16] = '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
                                4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_sb(input logic [3:0] x, input bit inv);
    if (!inv) return sbox_tab[x];
    for (int i = 0; i < 16; i++)
      if (sbox_tab[i] == x) return 4'(i);
    return 4'h0;
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [15:0] m_sub(input logic [15:0] x, input bit inv);
    for (int i = 0; i < 4; i++) x[i*4 +: 4] = m_sb(x[i*4 +: 4], inv);
    return x;
  endfunction

  function automatic logic [15:0] m_shift(input logic [15:0] x);
    return {x[15:12], x[3:0], x[7:4], x[11:8]};
  endfunction

  function automatic logic [15:0] m_mix(input logic [15:0] x);
    logic [15:0] y;
    for (int c = 0; c < 2; c++) begin
      y[15-8*c -: 4] = gf_mul(4'h3, x[15-8*c -: 4]) ^ gf_mul(4'h2, x[11-8*c -: 4]);
      y[11-8*c -: 4] = gf_mul(4'h2, x[15-8*c -: 4]) ^ gf_mul(4'h3, x[11-8*c -: 4]);
    end
    return y;
  endfunction

  function automatic logic [15:0] m_key(input logic [15:0] key, input int r);
    logic [15:0] k;
    logic [3:0]  rc;
    k  = key;
    rc = 4'h1;
    for (int i = 1; i <= r; i++) begin
      k[15:12] = k[15:12] ^ m_sb(k[3:0], 1'b0) ^ rc;
      k[11:8]  = k[11:8] ^ k[15:12];
      k[7:4]   = k[7:4] ^ k[11:8];
      k[3:0]   = k[3:0] ^ k[7:4];
      rc       = gf_mul(rc, 4'h2);
    end
    return k;
  endfunction

  function automatic logic [15:0] m_enc(input logic [15:0] key, input logic [15:0] d);
    logic [15:0] s;
    s = d ^ key;
    for (int r = 1; r <= R; r++) begin
      s = m_shift(m_sub(s, 1'b0));
      if (r < R) s = m_mix(s);
      s ^= m_key(key, r);
    end
    return s;
  endfunction

  function automatic logic [15:0] m_dec(input logic [15:0] key, input logic [15:0] c);
    logic [15:0] s;
    s = c ^ m_key(key, R);
    for (int r = R; r >= 1; r--) begin
      if (r < R) s = m_mix(s);
      s = m_sub(m_shift(s), 1'b1) ^ m_key(key, r - 1);
    end
    return s;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] md, input logic [15:0] key,
                        input logic [15:0] din, input logic [15:0] exp_d, input logic [15:0] exp_k,
                        input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    bus.bgn = 1'b1; bus.mode = md; bus.key_in = key; bus.data_in = din;
    @(posedge clk);
    #1;
    bus.bgn = 1'b0; bus.mode = 2'($urandom); bus.key_in = 16'($urandom); bus.data_in = 16'($urandom);
    @(negedge clk);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = bus.done;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_data"}, 32'(bus.data_out), 32'(exp_d));
    check_eq({tag, "_key"}, 32'(bus.key_out), 32'(exp_k));
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [15:0] ct, k, d;
    logic [1:0]  md;
    int          seen;

    bus.bgn = 1'b0; bus.mode = 2'b00; bus.key_in = '0; bus.data_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", 32'(bus.data_out), 32'd0);
    check_eq("rst_key", 32'(bus.key_out), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_round", 32'(bus.round), 32'd0);
    rst = 1'b0;

    run_op("enc_vec", 2'b01, 16'hC3F0, 16'h9C63, 16'h72C6, 16'h6696, R + 1);
    run_op("dec_vec", 2'b10, 16'hC3F0, 16'h72C6, 16'h9C63, 16'hC3F0, 2 * R + 1);

    ct = m_enc(16'h1325, 16'h59B3);
    run_op("rt_enc", 2'b01, 16'h1325, 16'h59B3, ct, m_key(16'h1325, R), R + 1);
    run_op("rt_dec", 2'b10, 16'h1325, bus.data_out, 16'h59B3, 16'h1325, 2 * R + 1);

    @(negedge clk);
    bus.bgn = 1'b1; bus.mode = 2'b01; bus.key_in = 16'h0000; bus.data_in = 16'h0000;
    @(posedge clk);
    #1 bus.bgn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("key0_k1", 32'(dut.k_q), 32'(m_key(16'h0000, 1)));
    repeat (4) @(negedge clk);
    check_eq("key0_kout", 32'(bus.key_out), 32'(m_key(16'h0000, R)));

    for (int i = 0; i < 16; i++) begin
      k  = 16'($urandom);
      d  = 16'($urandom);
      md = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      if (md == 2'b01) run_op("rnd_enc", md, k, d, m_enc(k, d), m_key(k, R), R + 1);
      else             run_op("rnd_dec", md, k, d, m_dec(k, d), k, 2 * R + 1);
    end

    for (int m = 0; m < 4; m += 3) begin
      @(negedge clk);
      bus.bgn = 1'b1; bus.mode = 2'(m);
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        seen += int'(bus.busy) + int'(bus.done);
      end
      bus.bgn = 1'b0;
      check_eq("nop_mode", 32'(seen), 32'd0);
    end

    k = 16'($urandom);
    d = 16'($urandom);
    @(negedge clk);
    bus.bgn = 1'b1; bus.mode = 2'b01; bus.key_in = k; bus.data_in = d;
    @(posedge clk);
    #1 bus.bgn = 1'b0;
    @(negedge clk);
    bus.bgn = 1'b1; bus.mode = 2'b10; bus.data_in = ~d;
    @(negedge clk);
    bus.bgn = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(bus.done);
    end
    check_eq("busy_ignore_dones", 32'(seen), 32'd1);
    check_eq("busy_ignore_data", 32'(bus.data_out), 32'(m_enc(k, d)));

    @(negedge clk);
    bus.bgn = 1'b1; bus.mode = 2'b01; bus.key_in = k; bus.data_in = d;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(bus.done);
    end
    bus.bgn = 1'b0;
    check_eq("held_restart", 32'(seen), 32'(12 / (R + 2)));
    repeat (6) @(negedge clk);

    @(negedge clk);
    bus.bgn = 1'b1; bus.mode = 2'b10; bus.key_in = 16'hA5A5; bus.data_in = 16'h1234;
    @(posedge clk);
    #1 bus.bgn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check_eq("mid_busy_before", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_data", 32'(bus.data_out), 32'd0);
    check_eq("mid_rst_key", 32'(bus.key_out), 32'd0);
    check_eq("mid_rst_round", 32'(bus.round), 32'd0);
    check_eq("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 2'b01, 16'hC3F0, 16'h9C63, 16'h72C6, 16'h6696, R + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
